sync_fifo_param: RTL

//  Single-clock parametrised FIFO: next generation of our FIFO family for same-domain buffering.

---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 102 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: the producer/consumer side drives the master modport.
// The FIFO itself attaches through the slave modport.
interface sync_fifo_param_if #(
  parameter int data_width = 8,
  parameter int depth      = 8
);
  localparam int cnt_width = $clog2(depth + 1);

  logic                  w_inc;
  logic [data_width-1:0] w_data;
  logic                  r_inc;
  logic                  err_clr;
  logic [data_width-1:0] r_data;
  logic                  r_valid;
  logic                  wfull;
  logic                  rempty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [cnt_width-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_inc, w_data, r_inc, err_clr,
    input  r_data, r_valid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_inc, w_data, r_inc, err_clr,
    output r_data, r_valid, wfull, rempty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary depth with occupancy count, programmable thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have 1-cycle latency.
module sync_fifo_param #(
  parameter int data_width = 8,
  parameter int depth      = 8,
  parameter int af_level   = 6,
  parameter int ae_level   = 2
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  fifo_if
);
  localparam int cnt_width = $clog2(depth + 1);
  localparam int ptr_width = $clog2(depth);

  logic [data_width-1:0] mem [depth];

  logic [ptr_width-1:0] wptr_reg, wptr_next;
  logic [ptr_width-1:0] rptr_reg, rptr_next;
  logic [cnt_width-1:0] count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;
  logic                 wfull, rempty, wr_ok, rd_ok;

  assign rempty = (count_reg == '0);
  assign wfull  = (count_reg == cnt_width'(depth));
  // Acceptance is judged on start-of-cycle state, so a simultaneous pop never frees room for a push.
  assign wr_ok  = fifo_if.w_inc && !wfull;
  assign rd_ok  = fifo_if.r_inc && !rempty;

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    count_next     = count_reg;
    overflow_next  = fifo_if.err_clr ? 1'b0 : overflow_reg;
    underflow_next = fifo_if.err_clr ? 1'b0 : underflow_reg;
    if (fifo_if.w_inc && wfull)
      overflow_next = 1'b1;
    if (fifo_if.r_inc && rempty)
      underflow_next = 1'b1;
    if (wr_ok)
      wptr_next = (wptr_reg == ptr_width'(depth - 1)) ? '0 : wptr_reg + ptr_width'(1);
    if (rd_ok)
      rptr_next = (rptr_reg == ptr_width'(depth - 1)) ? '0 : rptr_reg + ptr_width'(1);
    if (wr_ok && !rd_ok)
      count_next = count_reg + cnt_width'(1);
    else if (rd_ok && !wr_ok)
      count_next = count_reg - cnt_width'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr_reg] <= fifo_if.w_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo_if.r_data  = mem[rptr_reg];
  assign fifo_if.r_valid = !rempty;
`else
  logic [data_width-1:0] r_data_reg;
  logic                  r_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_reg  <= '0;
      r_valid_reg <= 1'b0;
    end else begin
      r_valid_reg <= rd_ok;
      if (rd_ok)
        r_data_reg <= mem[rptr_reg];
    end
  end

  assign fifo_if.r_data  = r_data_reg;
  assign fifo_if.r_valid = r_valid_reg;
`endif

  assign fifo_if.wfull        = wfull;
  assign fifo_if.rempty       = rempty;
  assign fifo_if.almost_full  = (count_reg >= cnt_width'(af_level));
  assign fifo_if.almost_empty = (count_reg <= cnt_width'(ae_level));
  assign fifo_if.count        = count_reg;
  assign fifo_if.overflow     = overflow_reg;
  assign fifo_if.underflow    = underflow_reg;
endmodule
